// File: rtl/histogram_multi.sv
`default_nettype none
// ============================================================================
// Module      : histogram_multi
// Description : Per-channel sample-code histogram over a window of
//               2^LOG2_WIN qualified samples. At each window end the scaled,
//               saturating bin counts are published with a one-cycle strobe
//               and a wrapping window sequence number.
// Ports       : clk      - sample clock
//               reset    - synchronous, active-high reset
//               x        - packed samples, channel c = x[c*BITS +: BITS]
//               x_valid  - sample qualifier
//               clear    - synchronous window restart (published data held)
//               h        - published bins, ch c / bin k at (c*NB+k)*OUT_W
//               h_valid  - one-cycle strobe on the cycle h updates
//               win_seq  - completed-window counter, wraps 255->0
// Revision    : 1.0 - initial release
// ============================================================================
module histogram_multi #(
  parameter int NCH      = 4,
  parameter int BITS     = 2,
  parameter int LOG2_WIN = 19,
  parameter int OUT_W    = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NCH*BITS-1:0]              x,
  input  logic                             x_valid,
  input  logic                             clear,
  output logic [NCH*(2**BITS)*OUT_W-1:0]   h,
  output logic                             h_valid,
  output logic [7:0]                       win_seq
);

  localparam int NB = 2**BITS;
  // One extra bit so a bin that takes every sample of the window fits.
  localparam int CW = LOG2_WIN + 1;
  localparam int SH = LOG2_WIN - OUT_W;
  localparam logic [CW-1:0] c_sat_max = CW'((64'd1 << OUT_W) - 64'd1);

  logic [LOG2_WIN-1:0] n_q, n_d;
  logic                h_valid_q, h_valid_d;
  logic [7:0]          win_seq_q, win_seq_d;
  logic                w_accept;
  logic                w_term;

  // clear has priority over x_valid, including on the terminal sample.
  assign w_accept = x_valid & ~clear;
  assign w_term   = w_accept & (n_q == {LOG2_WIN{1'b1}});

  always_comb begin
    n_d       = n_q;
    h_valid_d = w_term;
    win_seq_d = win_seq_q + 8'(w_term);
    if (clear) begin
      n_d = '0;
    end else if (x_valid) begin
      // The all-ones terminal count wraps naturally to zero.
      n_d = n_q + LOG2_WIN'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_q       <= '0;
      h_valid_q <= 1'b0;
      win_seq_q <= '0;
    end else begin
      n_q       <= n_d;
      h_valid_q <= h_valid_d;
      win_seq_q <= win_seq_d;
    end
  end

  assign h_valid = h_valid_q;
  assign win_seq = win_seq_q;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    for (genvar k = 0; k < NB; k++) begin : g_bin
      logic            w_hit;
      logic [CW-1:0]   w_sum;
      logic [CW-1:0]   w_scaled;
      logic [CW-1:0]   cnt_q, cnt_d;
      logic [OUT_W-1:0] h_q, h_d;

      assign w_hit    = w_accept && (x[c*BITS +: BITS] == BITS'(k));
      // Count including the current sample, so the terminal sample is
      // part of the published result.
      assign w_sum    = cnt_q + CW'(w_hit);
      assign w_scaled = w_sum >> SH;

      always_comb begin
        cnt_d = w_sum;
        h_d   = h_q;
        if (clear || w_term) begin
          cnt_d = '0;
        end
        if (w_term) begin
          // Only a bin holding the full window exceeds the output range.
          h_d = (w_scaled > c_sat_max) ? c_sat_max[OUT_W-1:0]
                                       : w_scaled[OUT_W-1:0];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_q <= '0;
          h_q   <= '0;
        end else begin
          cnt_q <= cnt_d;
          h_q   <= h_d;
        end
      end

      assign h[(c*NB+k)*OUT_W +: OUT_W] = h_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_histogram_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_histogram_multi
// Description : Self-checking bench for histogram_multi. Two instances share
//               the stimulus: one with no scaling (OUT_W = LOG2_WIN) and one
//               with a 2-bit output (scale shift of 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_histogram_multi;

  localparam int NCH = 2;
  localparam int BITS = 2;
  localparam int NB = 4;
  localparam int LW = 4;
  localparam int WIN = 16;
  localparam int OW_A = 4;
  localparam int OW_B = 2;

  logic clk = 1'b0;
  logic reset;
  logic [NCH*BITS-1:0] x;
  logic x_valid;
  logic clear;
  logic [NCH*NB*OW_A-1:0] h_a;
  logic [NCH*NB*OW_B-1:0] h_b;
  logic hv_a, hv_b;
  logic [7:0] seq_a, seq_b;

  always #5 clk = ~clk;

  histogram_multi #(.NCH(NCH), .BITS(BITS), .LOG2_WIN(LW), .OUT_W(OW_A)) u_dut_a (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .clear(clear),
    .h(h_a), .h_valid(hv_a), .win_seq(seq_a));

  histogram_multi #(.NCH(NCH), .BITS(BITS), .LOG2_WIN(LW), .OUT_W(OW_B)) u_dut_b (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .clear(clear),
    .h(h_b), .h_valid(hv_b), .win_seq(seq_b));

  int total = 0;
  int bad = 0;
  int hv_cnt = 0;
  bit chk_en = 1'b0;

  // Behavioural model: tally of the current window, and published values.
  int m_tally [NCH][NB];
  int m_taken;
  int m_pub [NCH][NB];
  bit m_hv;
  int m_seq;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int scale(input int v, input int ow);
    int s;
    int mx;
    s  = v >> (LW - ow);
    mx = (1 << ow) - 1;
    return (s > mx) ? mx : s;
  endfunction

  function automatic logic [63:0] pack(input int ow);
    logic [63:0] r;
    r = '0;
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < NB; k++)
        r = r | (64'(scale(m_pub[c][k], ow)) << ((c*NB + k) * ow));
    return r;
  endfunction

  always @(posedge clk) begin
    int t [NCH][NB];
    int taken;
    int p [NCH][NB];
    int sq;
    bit pv;
    t = m_tally; taken = m_taken; p = m_pub; sq = m_seq; pv = 1'b0;
    if (reset) begin
      for (int c = 0; c < NCH; c++)
        for (int k = 0; k < NB; k++) begin t[c][k] = 0; p[c][k] = 0; end
      taken = 0; sq = 0;
    end else if (clear) begin
      for (int c = 0; c < NCH; c++)
        for (int k = 0; k < NB; k++) t[c][k] = 0;
      taken = 0;
    end else if (x_valid) begin
      for (int c = 0; c < NCH; c++) t[c][int'(x[c*BITS +: BITS])]++;
      taken++;
      if (taken == WIN) begin
        p = t;
        pv = 1'b1;
        sq = (sq + 1) % 256;
        taken = 0;
        for (int c = 0; c < NCH; c++)
          for (int k = 0; k < NB; k++) t[c][k] = 0;
      end
    end
    m_tally <= t; m_taken <= taken; m_pub <= p; m_hv <= pv; m_seq <= sq;
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("h_a", 64'(h_a), pack(OW_A));
      check("h_b", 64'(h_b), pack(OW_B));
      check("h_valid_a", 64'(hv_a), 64'(m_hv));
      check("h_valid_b", 64'(hv_b), 64'(m_hv));
      check("win_seq_a", 64'(seq_a), 64'(m_seq));
      check("win_seq_b", 64'(seq_b), 64'(m_seq));
      if (hv_a === 1'b1) hv_cnt++;
    end
  end

  task automatic drive(input logic [3:0] xv, input bit v, input bit clr);
    @(negedge clk);
    reset = 1'b0; x = xv; x_valid = v; clear = clr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; x = '0; x_valid = 1'b1; clear = 1'b0;
  endtask

  int hv0;

  initial begin
    reset = 1'b1; x = '0; x_valid = 1'b0; clear = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_h", 64'(h_a), 64'h0);
    check("rst_hv", 64'(hv_a), 64'h0);
    check("rst_seq", 64'(seq_a), 64'h0);

    // Window 1: ch0 constant code 1, ch1 cycling 0..3.
    hv0 = hv_cnt;
    for (int i = 0; i < 16; i++) drive({2'(i % 4), 2'b01}, 1'b1, 1'b0);
    drive(4'h0, 1'b0, 1'b0);
    check("w1_h_a", 64'(h_a), 64'h4444_00F0);
    check("w1_h_b", 64'(h_b), 64'h550C);
    check("w1_hv", 64'(hv_a), 64'h1);
    check("w1_seq", 64'(seq_a), 64'h1);
    drive(4'h0, 1'b0, 1'b0);
    drive(4'h0, 1'b0, 1'b0);
    check("w1_pulses", 64'(hv_cnt - hv0), 64'd1);

    // Window 2: same samples with gaps on alternate cycles.
    hv0 = hv_cnt;
    for (int i = 0; i < 16; i++) begin
      drive({2'(i % 4), 2'b01}, 1'b1, 1'b0);
      drive(4'hA, 1'b0, 1'b0);
    end
    check("w2_h_a", 64'(h_a), 64'h4444_00F0);
    check("w2_seq", 64'(seq_a), 64'h2);
    drive(4'h0, 1'b0, 1'b0);
    check("w2_pulses", 64'(hv_cnt - hv0), 64'd1);

    // Partial window discarded by clear (clear wins over x_valid).
    hv0 = hv_cnt;
    for (int i = 0; i < 10; i++) drive(4'hF, 1'b1, 1'b0);
    drive(4'hF, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) drive(4'h0, 1'b1, 1'b0);
    drive(4'h0, 1'b0, 1'b0);
    check("clr_h_a", 64'(h_a), 64'h000F_000F);
    check("clr_h_b", 64'(h_b), 64'h0303);
    check("clr_seq", 64'(seq_a), 64'h3);
    drive(4'h0, 1'b0, 1'b0);
    check("clr_pulses", 64'(hv_cnt - hv0), 64'd1);

    // Clear on the terminal sample: no publication.
    for (int i = 0; i < 15; i++) drive(4'h5, 1'b1, 1'b0);
    drive(4'h5, 1'b1, 1'b1);
    drive(4'h0, 1'b0, 1'b0);
    check("clr_term_hv", 64'(hv_a), 64'h0);
    check("clr_term_seq", 64'(seq_a), 64'h3);

    // Two windows, then reset five samples into the third.
    for (int i = 0; i < 32; i++) drive(4'($urandom_range(0, 15)), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(4'($urandom_range(0, 15)), 1'b1, 1'b0);
    do_reset();
    drive(4'h0, 1'b0, 1'b0);
    check("mid_rst_h", 64'(h_a), 64'h0);
    check("mid_rst_hv", 64'(hv_a), 64'h0);
    check("mid_rst_seq", 64'(seq_a), 64'h0);
    // Full window of code 2 on ch0 and code 3 on ch1 publishes from zero.
    for (int i = 0; i < 16; i++) drive(4'hE, 1'b1, 1'b0);
    drive(4'h0, 1'b0, 1'b0);
    check("post_rst_h_a", 64'(h_a), 64'hF000_0F00);
    check("post_rst_h_b", 64'(h_b), 64'hC030);
    check("post_rst_seq", 64'(seq_a), 64'h1);

    // 257 windows from reset: sequence wraps to 1.
    do_reset();
    drive(4'h0, 1'b0, 1'b0);
    hv0 = hv_cnt;
    for (int w = 0; w < 257; w++)
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(0, 7) == 0) drive(4'($urandom_range(0, 15)), 1'b0, 1'b0);
        drive(4'($urandom_range(0, 15)), 1'b1, 1'b0);
      end
    drive(4'h0, 1'b0, 1'b0);
    drive(4'h0, 1'b0, 1'b0);
    check("wrap_seq", 64'(seq_a), 64'h1);
    check("wrap_pulses", 64'(hv_cnt - hv0), 64'd257);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/histogram_multi.md
Name: histogram_multi

Overview:
Parametrised successor to the per-channel 2-bit sample-statistics block used for AGC/level monitoring. It accumulates a full 2^BITS-bin histogram of raw sample codes for NCH channels over a window of 2^LOG2_WIN qualified samples. At each window end it publishes scaled, saturating bin counts together with a one-cycle strobe and a window sequence number. It sits after the ADC sample capture, in parallel with the datapath, and feeds gain-control firmware through the register interface.

Parameters:
NCH, 4, number of channels
BITS, 2, sample width per channel; bins per channel NB = 2^BITS
LOG2_WIN, 19, window length = 2^LOG2_WIN accepted samples
OUT_W, 8, published bin width; legal values satisfy 1 <= OUT_W <= LOG2_WIN

Ports:
clk  in  1  sample clock
reset  in  1  synchronous, active-high reset
x  in  NCH*BITS  packed samples; channel c = x[c*BITS +: BITS]
x_valid  in  1  sample qualifier; samples are counted only when high
clear  in  1  synchronous window restart; does not touch published outputs
h  out  NCH*NB*OUT_W  published bins; channel c, bin k = h[(c*NB+k)*OUT_W +: OUT_W]
h_valid  out  1  one-cycle strobe, high on the cycle h updates
win_seq  out  8  completed-window counter, wraps 255->0

Behaviour:
- State: sample counter n (LOG2_WIN bits); per channel and per bin a counter cnt[c][k] (LOG2_WIN+1 bits, so it can hold a full window).
- reset: n, all cnt, h, win_seq = 0; h_valid = 0. Reset mid-window discards the partial window.
- Bin mapping: bin index = raw sample code. Code k on channel c increments only cnt[c][k]. Every accepted sample lands in exactly one bin per channel.
- Accepted sample (x_valid=1, clear=0, n != 2^LOG2_WIN-1):
  - n <= n+1.
  - Each cnt[c][x_c] <= cnt[c][x_c]+1.
- Terminal sample (x_valid=1, clear=0, n == 2^LOG2_WIN-1): this sample is included in the published result. On the same edge:
  - h[c][k] <= sat(cnt[c][k] + (x_c==k)).
  - h_valid <= 1.
  - win_seq <= win_seq+1.
  - n <= 0; all cnt <= 0.
- Publication latency: h and h_valid change on the clock edge that accepts the terminal sample, so they are visible on the next cycle. h_valid lasts exactly one cycle. h holds its value until the next publication.
- Per channel, the pre-scaling counts of a window sum to exactly 2^LOG2_WIN.
- sat(v):
  - s = v >> (LOG2_WIN-OUT_W).
  - If s > 2^OUT_W-1, the result is 2^OUT_W-1; otherwise it is s.
  - Only a bin that receives every sample of the window (v = 2^LOG2_WIN) saturates.
- x_valid=0: no state changes except h_valid <= 0. Gaps in x_valid stretch the window without affecting the counts.
- clear=1:
  - n and all cnt <= 0.
  - The sample on the same cycle is discarded (clear wins over x_valid, including on the terminal cycle).
  - No publication occurs; h and win_seq are held; h_valid <= 0.
- Counters never wrap within a window, because the width is sized for a full window.
- Registers only, no combinational input-to-output paths.

Test Plan:
- Use NCH=2, BITS=2, LOG2_WIN=4, OUT_W=4 (window 16, shift 0) unless noted.
- Reset, then 16 valid samples with ch0=2'b01 and ch1 cycling 0,1,2,3 -> one h_valid pulse after the 16th sample; ch0 bins = {0,15(sat),0,0}; ch1 bins = {4,4,4,4}; win_seq=1.
- Same 16 samples with x_valid low on alternate cycles -> identical h; h_valid asserts one cycle after the 16th accepted sample (32 cycles after the start), never earlier.
- 10 samples of code 3, then clear pulsed together with x_valid, then 16 samples of code 0 -> ch0 bins = {15,0,0,0}; the discarded samples leave no trace; win_seq increments once; no h_valid during clear.
- Two complete windows, then reset asserted 5 samples into the third -> h=0, h_valid=0, win_seq=0 on the cycle after reset; the next full window publishes from zero.
- Defaults (LOG2_WIN=19, OUT_W=8), ch0 pattern of 2^17 code-0 and 3*2^17 code-2 samples -> ch0 bins = {64,0,192,0}; h_valid pulses exactly 524288 accepted samples after reset.
- 256+1 complete windows -> win_seq wraps to 1; h_valid count equals 257.
